// File: rtl/power_sequence_generator.sv
// Streams k*s, (k*s)^2 and (k*s)^3 for k = 0..L by forward differencing.
// A serial shift-add multiplier builds s^2 and s^3 once per job.
module power_sequence_generator #(
    parameter int IDX_W  = 4,
    parameter int STEP_W = 4,
    parameter int XW     = IDX_W + STEP_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [STEP_W-1:0]   step,
    input  logic [IDX_W-1:0]    last_idx,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_idx,
    output logic [XW-1:0]       out_x,
    output logic [2*XW-1:0]     out_sq,
    output logic [3*XW-1:0]     out_cube,
    output logic                done
);

    localparam int CW = $clog2(2*STEP_W + 1);
    localparam int SW = 2*XW + 2;
    localparam int DW = 3*XW + 3;
    localparam int MW = 3*STEP_W;

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t              state_q;
    logic [STEP_W-1:0]   s_q;
    logic [STEP_W-1:0]   mplr_q;
    logic [IDX_W-1:0]    last_q;
    logic [CW-1:0]       cnt_q;
    logic [MW-1:0]       mcand_q;
    logic [MW-1:0]       acc_q;
    logic [2*STEP_W-1:0] s2_q;
    logic [SW-1:0]       e1_q, e2_q;
    logic [DW-1:0]       d1_q, d2_q, d3_q;

    logic [MW-1:0]       acc_sum;
    logic [DW-1:0]       d6_init;
    logic                accept;

    always_comb begin
        acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
        d6_init = (DW'(acc_q) << 2) + (DW'(acc_q) << 1);
        accept  = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            mplr_q    <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            s2_q      <= '0;
            e1_q      <= '0;
            e2_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_x     <= '0;
            out_sq    <= '0;
            out_cube  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        s_q     <= step;
                        last_q  <= last_idx;
                        mplr_q  <= step;
                        mcand_q <= MW'(step);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    if (cnt_q == CW'(2*STEP_W)) begin
                        // acc_q now holds s^3; seed the difference engines
                        e1_q      <= SW'(s2_q);
                        e2_q      <= SW'(s2_q) << 1;
                        d1_q      <= DW'(acc_q);
                        d2_q      <= d6_init;
                        d3_q      <= d6_init;
                        out_idx   <= '0;
                        out_x     <= '0;
                        out_sq    <= '0;
                        out_cube  <= '0;
                        out_valid <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(STEP_W - 1)) begin
                            s2_q    <= acc_sum[2*STEP_W-1:0];
                            acc_q   <= '0;
                            mcand_q <= MW'(acc_sum[2*STEP_W-1:0]);
                            mplr_q  <= s_q;
                        end else begin
                            acc_q   <= acc_sum;
                            mcand_q <= mcand_q << 1;
                            mplr_q  <= mplr_q >> 1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (out_idx == last_q) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            out_idx  <= out_idx + 1'b1;
                            out_x    <= out_x + XW'(s_q);
                            out_sq   <= out_sq + e1_q[2*XW-1:0];
                            e1_q     <= e1_q + e2_q;
                            out_cube <= out_cube + d1_q[3*XW-1:0];
                            d1_q     <= d1_q + d2_q;
                            d2_q     <= d2_q + d3_q;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
